// File: rtl/lfsr_clt_sampler.sv
// Consumer of a 151-bit, 7-bit-per-step LFSR: sums NUM_SUM fresh samples, re-centres the sum
// to a signed zero-mean value and hands it out through a 2-entry valid/ready buffer.
module lfsr_clt_sampler #(
   parameter int SAMPLE_W = 7,
   parameter int NUM_SUM  = 4,
   localparam int OUT_W   = SAMPLE_W + $clog2(NUM_SUM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_valid,
   input  logic [150:0]     seed,
   output logic             lfsr_set,
   output logic [150:0]     lfsr_seed,
   output logic             lfsr_advance,
   input  logic [150:0]     lfsr_state,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             seeded
);

   localparam int CNT_W = $clog2(NUM_SUM);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SUM - 1);

   typedef enum logic {S_UNSEEDED, S_ACCUM} state_t;

   state_t           r_state;
   logic [OUT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [OUT_W-1:0] r_buf0;
   logic [OUT_W-1:0] r_buf1;
   logic [1:0]       r_count;
   logic             r_valid;
   logic             r_seeded;

   logic             w_step;
   logic             w_last;
   logic             w_push;
   logic             w_pop;
   logic [OUT_W-1:0] w_sample;
   logic [OUT_W-1:0] w_sum;
   logic [OUT_W-1:0] w_centred;
   logic [1:0]       w_count_next;
   logic             w_unused_state;

   assign lfsr_set  = seed_valid;
   assign lfsr_seed = seed;

   assign w_sample = {{CNT_W{1'b0}}, lfsr_state[SAMPLE_W-1:0]};
   assign w_sum    = r_acc + w_sample;
   // Subtracting NUM_SUM*2^(SAMPLE_W-1) from an OUT_W-bit sum is exactly an MSB flip.
   assign w_centred = {~w_sum[OUT_W-1], w_sum[OUT_W-2:0]};

   // The stall test uses the buffer count before any pop, so a full buffer never steps.
   assign w_step       = (r_state == S_ACCUM) && (r_count != 2'd2) && !seed_valid;
   assign w_last       = (r_cnt == LAST_CNT);
   assign w_push       = w_step && w_last;
   assign w_pop        = r_valid && out_ready;
   assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

   assign w_unused_state = ^lfsr_state[150:SAMPLE_W];

   assign lfsr_advance = w_step;
   assign out_valid    = r_valid;
   assign out_data     = r_buf0;
   assign seeded       = r_seeded;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_UNSEEDED;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_buf0   <= '0;
         r_buf1   <= '0;
         r_count  <= 2'd0;
         r_valid  <= 1'b0;
         r_seeded <= 1'b0;
      end else if (seed_valid) begin
         r_state  <= S_ACCUM;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_buf0   <= '0;
         r_buf1   <= '0;
         r_count  <= 2'd0;
         r_valid  <= 1'b0;
         r_seeded <= 1'b1;
      end else begin
         if (w_step) begin
            if (w_last) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end

         // A push can only meet a pop at count 1, where the new entry becomes head.
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_buf0 <= w_centred;
               else                 r_buf1 <= w_centred;
            end
            2'b01:   r_buf0 <= r_buf1;
            2'b11:   r_buf0 <= w_centred;
            default: ;
         endcase

         r_count <= w_count_next;
         r_valid <= (w_count_next != 2'd0);
      end
   end

endmodule

// File: tb/tb_lfsr_clt_sampler.sv
// Bench for lfsr_clt_sampler: stub LFSR (constant or real trinomial LFSR), directed checks
// and a golden stream model that predicts every output from the seed alone.
module tb_lfsr_clt_sampler;

   logic         clk;
   logic         rst;
   logic         seed_valid;
   logic [150:0] seed;
   logic         lfsr_set;
   logic [150:0] lfsr_seed;
   logic         lfsr_advance;
   logic [150:0] lfsr_state;
   logic         out_valid;
   logic         out_ready;
   logic [8:0]   out_data;
   logic         seeded;

   int n_checks = 0;
   int n_fail   = 0;

   logic         const_mode = 1'b1;
   logic [6:0]   const_val  = 7'd0;
   logic [150:0] lfsr_reg   = '0;
   logic         chk_en     = 1'b0;

   lfsr_clt_sampler dut (
      .clk          (clk),
      .rst          (rst),
      .seed_valid   (seed_valid),
      .seed         (seed),
      .lfsr_set     (lfsr_set),
      .lfsr_seed    (lfsr_seed),
      .lfsr_advance (lfsr_advance),
      .lfsr_state   (lfsr_state),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .seeded       (seeded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // x^151 + x^3 + 1, seven single-bit shifts per step
   function automatic logic [150:0] lfsr_step(input logic [150:0] s);
      logic [150:0] t;
      t = s;
      for (int i = 0; i < 7; i++) t = {t[149:0], t[150] ^ t[2]};
      return t;
   endfunction

   function automatic logic [150:0] rand151();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[150:0];
   endfunction

   always_ff @(posedge clk) begin
      if (lfsr_set)          lfsr_reg <= lfsr_seed;
      else if (lfsr_advance) lfsr_reg <= lfsr_step(lfsr_reg);
   end
   assign lfsr_state = const_mode ? {144'd0, const_val} : lfsr_reg;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Golden model: the k-th output after a seed is the sum of states 4k..4k+3 (low 7 bits) minus 256.
   logic [150:0] m_state;
   int           m_head;
   bit           m_seeded = 1'b0;

   task automatic gen_next();
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         s += int'(m_state[6:0]);
         m_state = lfsr_step(m_state);
      end
      m_head = s - 256;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (rst) begin
            m_seeded = 1'b0;
            check("valid_in_reset", longint'(out_valid), 0);
         end else begin
            if (out_valid && m_seeded) begin
               check("stream_data", longint'($signed(out_data)), longint'(m_head));
               if (out_ready && !seed_valid) gen_next();
            end
            if (seed_valid) begin
               m_state  = seed;
               m_seeded = 1'b1;
               gen_next();
            end
         end
      end
   end

   task automatic seed_const(input logic [6:0] v, input int exp);
      @(posedge clk); #1;
      const_val  = v;
      seed       = rand151();
      seed_valid = 1'b1;
      @(negedge clk);
      check("lfsr_set", longint'(lfsr_set), 1);
      check("lfsr_seed_eq", longint'(lfsr_seed == seed), 1);
      check("adv_on_seed", longint'(lfsr_advance), 0);
      @(posedge clk); #1;
      seed_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) check("adv_first_step", longint'(lfsr_advance), 1);
         if (c < 5) check("valid_latency", longint'(out_valid), 0);
         else begin
            check("valid_rise", longint'(out_valid), 1);
            check("const_data", longint'($signed(out_data)), longint'(exp));
         end
         if (c < 5) @(posedge clk);
      end
   endtask

   initial begin
      int cyc, nacc, v;
      longint sum;
      logic [8:0] d0;

      rst = 1'b1; seed_valid = 1'b0; seed = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid",   longint'(out_valid), 0);
      check("rst_data",    longint'(out_data), 0);
      check("rst_seeded",  longint'(seeded), 0);
      check("rst_advance", longint'(lfsr_advance), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("unseeded_advance", longint'(lfsr_advance), 0);
      end

      seed_const(7'd0,   -256);
      seed_const(7'd127,  252);
      seed_const(7'd64,     0);

      // Real LFSR, continuous ready: values, pinned first outputs, throughput, statistics
      @(posedge clk); #1;
      const_mode = 1'b0; chk_en = 1'b1; seed = 151'h1; seed_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      seed_valid = 1'b0;
      cyc = 0; nacc = 0; sum = 0;
      while (nacc < 1000 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (out_valid && out_ready) begin
            nacc++;
            v = int'($signed(out_data));
            sum += v;
            check("range", longint'(v >= -256 && v <= 252), 1);
            if (nacc == 1) check("pin_first", longint'(v), -128);
            if (nacc == 2) check("pin_second", longint'(v), -111);
            if (nacc == 1000) check("throughput_cycle", longint'(cyc), 4001);
         end
         @(posedge clk);
      end
      check("sample_count", longint'(nacc), 1000);
      check("mean_ok", longint'(sum >= -8000 && sum <= 8000), 1);

      // Back-pressure: buffer fills, LFSR stalls, data holds, stream resumes without gaps
      #1 out_ready = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("stall_adv", longint'(lfsr_advance), 0);
      check("stall_valid", longint'(out_valid), 1);
      d0 = out_data;
      repeat (3) begin
         @(negedge clk);
         check("stall_hold", longint'(out_data), longint'(d0));
         check("stall_adv_hold", longint'(lfsr_advance), 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (40) @(posedge clk);

      // Reseed mid-sum (cnt=2) while an entry is held and ready is high
      #1 out_ready = 1'b0;
      repeat (12) @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("full_no_adv", longint'(lfsr_advance), 0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("step_after_pop", longint'(lfsr_advance), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("step_cnt1", longint'(lfsr_advance), 1);
      @(posedge clk); #1;
      seed = rand151(); seed_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("held_before_seed", longint'(out_valid), 1);
      @(posedge clk); #1;
      seed_valid = 1'b0;
      @(negedge clk);
      check("flush_valid", longint'(out_valid), 0);
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         if (c < 5) check("reseed_latency", longint'(out_valid), 0);
         else       check("reseed_valid", longint'(out_valid), 1);
      end

      // Asynchronous reset in the middle of a cycle
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_valid",   longint'(out_valid), 0);
      check("arst_seeded",  longint'(seeded), 0);
      check("arst_advance", longint'(lfsr_advance), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_adv", longint'(lfsr_advance), 0);
         check("post_rst_valid", longint'(out_valid), 0);
      end
      @(posedge clk); #1;
      seed = rand151(); seed_valid = 1'b1;
      @(posedge clk); #1;
      seed_valid = 1'b0;
      @(negedge clk);
      check("seeded_set", longint'(seeded), 1);
      check("adv_after_seed", longint'(lfsr_advance), 1);

      // Randomized ready and occasional reseeds, checked by the stream model
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            seed = rand151();
            seed_valid = 1'b1;
         end else begin
            seed_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      seed_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
